prog_ram: RTL and testbench

Parametrised program/data RAM for the 4-bit CPU, replacing the fixed 8-bit x 16-word array. The CPU port gives an asynchronous or registered read and a synchronous write. A built-in sequencer zero-fills the array after reset and accepts a streamed program image over a valid/ready load port, so a host or UART bridge can reprogram the CPU without resynthesis. The block sits between the CPU core (instruction fetch / data access) and the board-level loader.

---
 rtl/prog_ram.sv | 167 ++++++++++++++++
 tb/tb_prog_ram.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_ram.sv
// prog_ram: parametrised CPU program/data RAM with a built-in zero-fill and stream-load sequencer.
// Latency: writes commit on the rising edge; reads are combinational (READ_REG=0) or one cycle, write-first (READ_REG=1).
// Backpressure: ld_ready is high only in LOAD; CPU writes are dropped while busy; CPU reads are always serviced.
//
// Ports:
//   clk, rst_n             single clock, synchronous active-low reset
//   cpu_r_addr/cpu_r_data  CPU read port
//   cpu_we/w_addr/w_data   CPU write port (ignored while busy)
//   ld_start/ld_base       start a load session at ld_base (sampled in IDLE only)
//   ld_valid/ld_data/ld_last/ld_ready  streamed load words, ld_last closes the session
//   ld_done                one-cycle pulse after the last word is written
//   ld_ovf                 sticky, set when a session writes more than DEPTH words
//   busy                   high whenever the sequencer owns the write port
module prog_ram #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int READ_REG       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_r_addr,
  output logic [DATA_W-1:0] cpu_r_data,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_w_addr,
  input  logic [DATA_W-1:0] cpu_w_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_ovf,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  localparam state_e ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;     // clear / load address
  logic [ADDR_W:0]     len_q, len_d;     // words accepted this session, saturating
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic                ld_acc;
  logic                wr_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign ld_acc = (state_q == ST_LOAD) && ld_valid;

  // State and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        // all-ones counter is the last address, DEPTH-1
        if (&cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          cnt_d   = ld_base;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (len_q != '1) len_d = len_q + 1'b1;
          // DEPTH words already accepted: this one overwrites the session's own data
          if (len_q >= (ADDR_W + 1)'(DEPTH)) ovf_d = 1'b1;
          if (ld_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Output logic: write-port ownership and status
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cpu_w_addr;
    wr_data = cpu_w_data;
    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
      end
      ST_IDLE: begin
        wr_en = cpu_we;
      end
      ST_LOAD: begin
        wr_en   = ld_valid;
        wr_addr = cnt_q;
        wr_data = ld_data;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // A reset cycle aborts the sequencer before its write lands
  assign mem_we   = wr_en && rst_n;
  assign ld_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign ld_done  = done_q;
  assign ld_ovf   = ovf_q;

  // Storage is not reset; only CLEAR zeroes it
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (!rst_n)                                rd_q <= '0;
        else if (mem_we && wr_addr == cpu_r_addr)  rd_q <= wr_data;   // write-first
        else                                       rd_q <= mem[cpu_r_addr];
      end
      assign cpu_r_data = rd_q;
    end else begin : g_rd_comb
      assign cpu_r_data = mem[cpu_r_addr];
    end
  endgenerate

endmodule

// File: tb/tb_prog_ram.sv
// tb_prog_ram: drives a combinational-read and a registered-read prog_ram with identical stimulus.
// Latency: reference memory is updated at each edge; registered read expects post-edge contents.
// Backpressure: load words are streamed with random single-cycle gaps.
module tb_prog_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] cpu_r_addr, cpu_w_addr, ld_base;
  logic [7:0] cpu_w_data, ld_data;
  logic       cpu_we, ld_start, ld_valid, ld_last;

  logic [7:0] rd0, rd1;
  logic       rdy0, rdy1, done0, done1, ovf0, ovf1, busy0, busy1;

  prog_ram #(.DATA_W(8), .ADDR_W(4), .READ_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_r_addr(cpu_r_addr), .cpu_r_data(rd0),
    .cpu_we(cpu_we), .cpu_w_addr(cpu_w_addr), .cpu_w_data(cpu_w_data),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(rdy0), .ld_done(done0), .ld_ovf(ovf0), .busy(busy0)
  );

  prog_ram #(.DATA_W(8), .ADDR_W(4), .READ_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_r_addr(cpu_r_addr), .cpu_r_data(rd1),
    .cpu_we(cpu_we), .cpu_w_addr(cpu_w_addr), .cpu_w_data(cpu_w_data),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(rdy1), .ld_done(done1), .ld_ovf(ovf1), .busy(busy1)
  );

  logic [7:0] mem_m [16];
  logic [7:0] ld_words [32];
  bit         rd_chk_en;
  logic       exp_ovf;
  int         n_vec, n_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input logic b, input logic r, input logic d, input logic o);
    chk("busy0", {7'd0, busy0}, {7'd0, b});
    chk("busy1", {7'd0, busy1}, {7'd0, b});
    chk("ready0", {7'd0, rdy0}, {7'd0, r});
    chk("ready1", {7'd0, rdy1}, {7'd0, r});
    chk("done0", {7'd0, done0}, {7'd0, d});
    chk("done1", {7'd0, done1}, {7'd0, d});
    chk("ovf0", {7'd0, ovf0}, {7'd0, o});
    chk("ovf1", {7'd0, ovf1}, {7'd0, o});
  endtask

  // One clock: check the combinational read before the edge, apply the
  // expected write, then check the registered read after the edge.
  task automatic tick(input logic mw, input logic [3:0] mwa, input logic [7:0] mwd);
    logic [3:0] ra;
    logic       rl;
    ra = cpu_r_addr;
    rl = rst_n;
    #1;
    if (rd_chk_en) chk("rd_comb", rd0, mem_m[ra]);
    @(posedge clk);
    if (mw) mem_m[mwa] = mwd;
    #1;
    if (!rl)            chk("rd_reg_rst", rd1, 8'h00);
    else if (rd_chk_en) chk("rd_reg", rd1, mem_m[ra]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cpu_we = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cpu_r_addr = 4'($urandom);
      tick(1'b0, 4'd0, 8'd0);
      ctl(1'b1, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
  endtask

  // Zero-fill runs addresses 0..15 in order; a CPU write mid-fill must be dropped.
  task automatic wait_clear();
    int n;
    n = 0;
    while (busy0 && n < 40) begin
      cpu_r_addr = 4'($urandom);
      cpu_we     = (n == 8);
      cpu_w_addr = 4'd5;
      cpu_w_data = 8'h77;
      tick(n < 16, n[3:0], 8'h00);
      n++;
    end
    cpu_we = 1'b0;
    chk("clear_cycles", 8'(n), 8'd16);
    exp_ovf = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sweep();
    for (int a = 0; a < 16; a++) begin
      cpu_r_addr = 4'(a);
      tick(1'b0, 4'd0, 8'd0);
    end
  endtask

  task automatic do_load(input logic [3:0] base, input int n, input int abort_at);
    logic [3:0] wa;
    logic [7:0] wd;
    ctl(1'b0, 1'b0, 1'b0, exp_ovf);
    wa = 4'($urandom);
    wd = 8'($urandom);
    cpu_r_addr = 4'($urandom);
    ld_start = 1'b1; ld_base = base;
    cpu_we = 1'b1; cpu_w_addr = wa; cpu_w_data = wd;
    tick(1'b1, wa, wd);                    // CPU write in the start cycle still lands
    ld_start = 1'b0; cpu_we = 1'b0;
    exp_ovf = 1'b0;
    ctl(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0; ld_last = 1'($urandom);
        ld_start = 1'($urandom); ld_base = 4'($urandom);
        cpu_we = 1'b1; cpu_w_addr = 4'($urandom); cpu_w_data = 8'($urandom);
        cpu_r_addr = 4'($urandom);
        tick(1'b0, 4'd0, 8'd0);
        ctl(1'b1, 1'b1, 1'b0, exp_ovf);
      end
      if (i == abort_at) begin
        cpu_we = 1'b0; ld_start = 1'b0;
        rst_n = 1'b0;
        ld_valid = 1'b1; ld_data = ld_words[i]; ld_last = 1'b0;
        cpu_r_addr = base + 4'(i);
        tick(1'b0, 4'd0, 8'd0);
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        ld_valid = 1'b0;
        for (int j = 0; j <= i; j++) begin
          cpu_r_addr = base + 4'(j);
          tick(1'b0, 4'd0, 8'd0);
          ctl(1'b1, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        return;
      end
      ld_valid = 1'b1; ld_data = ld_words[i]; ld_last = (i == n - 1);
      ld_start = 1'($urandom);
      cpu_we = 1'b1; cpu_w_addr = 4'($urandom); cpu_w_data = 8'($urandom);
      cpu_r_addr = 4'($urandom);
      tick(1'b1, base + 4'(i), ld_words[i]);
      if (i >= 16) exp_ovf = 1'b1;
      if (i == n - 1) ctl(1'b0, 1'b0, 1'b1, exp_ovf);
      else            ctl(1'b1, 1'b1, 1'b0, exp_ovf);
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0; cpu_we = 1'b0;
    tick(1'b0, 4'd0, 8'd0);
    ctl(1'b0, 1'b0, 1'b0, exp_ovf);
  endtask

  initial begin
    n_vec = 0; n_err = 0; rd_chk_en = 0; exp_ovf = 1'b0;
    rst_n = 1'b0; cpu_r_addr = 4'd0; cpu_w_addr = 4'd0; cpu_w_data = 8'd0; cpu_we = 1'b0;
    ld_start = 1'b0; ld_base = 4'd0; ld_valid = 1'b0; ld_data = 8'd0; ld_last = 1'b0;

    // Power-up reset and first zero-fill
    do_reset();
    wait_clear();
    rd_chk_en = 1;

    // Pre-write 0xAA everywhere, then reset must clear it (not reset itself)
    for (int a = 0; a < 16; a++) begin
      cpu_we = 1'b1; cpu_w_addr = 4'(a); cpu_w_data = 8'hAA; cpu_r_addr = 4'($urandom);
      tick(1'b1, 4'(a), 8'hAA);
    end
    cpu_we = 1'b0;
    sweep();
    do_reset();
    wait_clear();
    sweep();

    // Random CPU traffic in IDLE
    for (int k = 0; k < 24; k++) begin
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
      we = 1'($urandom); wa = 4'($urandom); wd = 8'($urandom);
      cpu_we = we; cpu_w_addr = wa; cpu_w_data = wd;
      cpu_r_addr = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      tick(we, wa, wd);
    end
    // Same-address write and read: old data combinationally, new data registered
    cpu_we = 1'b1; cpu_w_addr = 4'd3; cpu_w_data = 8'h5C; cpu_r_addr = 4'd3;
    tick(1'b1, 4'd3, 8'h5C);
    cpu_we = 1'b0; cpu_r_addr = 4'd4;
    tick(1'b0, 4'd0, 8'd0);
    ctl(1'b0, 1'b0, 1'b0, 1'b0);

    // Two-word load at base 0
    ld_words[0] = 8'h66; ld_words[1] = 8'h90;
    do_load(4'd0, 2, -1);
    // Wrap across the top of the array
    for (int i = 0; i < 4; i++) ld_words[i] = 8'(i + 1);
    do_load(4'd14, 4, -1);
    sweep();
    // Overflow: 17 words from base 0, word 17 lands on address 0
    for (int i = 0; i < 17; i++) ld_words[i] = 8'($urandom);
    do_load(4'd0, 17, -1);
    sweep();
    // Next session clears the sticky overflow
    for (int i = 0; i < 5; i++) ld_words[i] = 8'($urandom);
    do_load(4'($urandom), 5, -1);
    for (int r = 0; r < 2; r++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) ld_words[i] = 8'($urandom);
      do_load(4'($urandom), len, -1);
    end
    sweep();

    // Reset after 3 of 8 words: words kept, no done pulse, back into CLEAR
    for (int i = 0; i < 8; i++) ld_words[i] = 8'($urandom);
    do_load(4'($urandom), 8, 3);
    wait_clear();
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
